// File: rtl/issue_ctrl_if.sv
// Handshake bundle between fetcher, issue controller and decoder/dispatch.
// The slave modport is the issue controller; the master modport is its environment.
interface issue_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              rdy_in;
  logic              clear_in;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic              iq_full;
  logic              dec_valid;
  logic [INST_W-1:0] dec_inst;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_is_ls;
  logic              rob_full;
  logic              rs_full;
  logic              lsb_full;
  logic              issue_en;
  logic              issue_to_lsb;
  logic [31:0]       stall_cnt;

  modport master (
    output rdy_in, clear_in, if_valid, if_inst, if_pc, dec_is_ls, rob_full, rs_full, lsb_full,
    input  iq_full, dec_valid, dec_inst, dec_pc, issue_en, issue_to_lsb, stall_cnt
  );

  modport slave (
    input  rdy_in, clear_in, if_valid, if_inst, if_pc, dec_is_ls, rob_full, rs_full, lsb_full,
    output iq_full, dec_valid, dec_inst, dec_pc, issue_en, issue_to_lsb, stall_cnt
  );
endinterface

// File: rtl/issue_ctrl.sv
// Issue controller: circular instruction queue between fetcher and decoder.
// Presents the queue head to the decoder and pops it only when the ROB and the
// selected target (RS or LSB) both have room. A mispredict flush empties the
// queue and blocks fetch for one redirect cycle (FLUSH state).
module issue_ctrl #(
  parameter int IQ_LOG = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  issue_ctrl_if.slave   bus
);
  localparam int                DEPTH   = 1 << IQ_LOG;
  localparam logic [IQ_LOG:0]   DEPTH_C = (IQ_LOG + 1)'(DEPTH);
  localparam logic [31:0]       STALL_MAX = 32'hFFFF_FFFF;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IQ_LOG-1:0] head_q, tail_q;
  logic [IQ_LOG:0]   count_q;
  logic [31:0]       stall_q;
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic push, pop, do_flush, stall;

  // Queue status, issue decision and next state.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d          = state_q;
    bus.iq_full      = (count_q == DEPTH_C) | (state_q == FLUSH);
    bus.dec_valid    = (count_q != '0) & (state_q == RUN);
    bus.dec_inst     = inst_mem[head_q];
    bus.dec_pc       = pc_mem[head_q];
    bus.issue_en     = bus.dec_valid & bus.rdy_in & ~bus.clear_in & ~bus.rob_full &
                       (bus.dec_is_ls ? ~bus.lsb_full : ~bus.rs_full);
    bus.issue_to_lsb = bus.issue_en & bus.dec_is_ls;
    bus.stall_cnt    = stall_q;
    do_flush         = bus.rdy_in & bus.clear_in;
    push             = bus.if_valid & ~bus.iq_full & bus.rdy_in & ~bus.clear_in;
    pop              = bus.issue_en;
    stall            = bus.rdy_in & bus.dec_valid & ~bus.issue_en & ~bus.clear_in;
    if (do_flush) begin
      state_d = FLUSH;
    end else if (bus.rdy_in && state_q == FLUSH) begin
      state_d = RUN;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Head/tail/count pointers; a flush empties the queue, rdy_in=0 freezes it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (do_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.rdy_in) begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage written at tail on an accepted push.
  // NOTE: the storage array has no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail_q] <= bus.if_inst;
      pc_mem[tail_q]   <= bus.if_pc;
    end
  end

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                          stall_q <= '0;
    else if (stall && stall_q != STALL_MAX) stall_q <= stall_q + 32'd1;
  end
endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized bench for issue_ctrl. A queue-level reference model predicts which
// instruction issues each cycle; predicted issues go into a scoreboard queue that
// an independent monitor drains whenever the DUT strobes issue_en.
module tb_issue_ctrl;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  logic clk_in = 1'b0;
  logic rst_in;

  issue_ctrl_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  issue_ctrl #(.IQ_LOG(4), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Decoder stand-in: bit 0 of the instruction marks a load/store.
  assign bus.dec_is_ls = bus.dec_inst[0];

  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  typedef struct { int cyc; logic [31:0] inst; logic [31:0] pc; bit to_lsb; } exp_t;

  ent_t        mq[$];      // model queue contents
  exp_t        exp_q[$];   // predicted issues awaiting the monitor
  bit          m_flush;
  longint      m_stall;
  int          cyc;
  int          checks;
  int          errors;
  logic [31:0] nxt_inst;
  logic [31:0] nxt_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus plus the model's view of that cycle.
  task automatic step(input bit v, input bit clr, input bit rdy,
                      input bit rob, input bit rs, input bit lsb);
    bit m_full, m_dv, m_ls, m_issue, m_push;
    @(negedge clk_in);
    #1;
    bus.if_valid = v;
    bus.if_inst  = nxt_inst;
    bus.if_pc    = nxt_pc;
    bus.clear_in = clr;
    bus.rdy_in   = rdy;
    bus.rob_full = rob;
    bus.rs_full  = rs;
    bus.lsb_full = lsb;
    #1;
    m_full  = (mq.size() == DEPTH) || m_flush;
    m_dv    = (mq.size() != 0) && !m_flush;
    check("iq_full", 64'(bus.iq_full), 64'(m_full));
    check("dec_valid", 64'(bus.dec_valid), 64'(m_dv));
    check("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
    if (m_dv) check("dec_pc", 64'(bus.dec_pc), 64'(mq[0].pc));
    m_ls    = m_dv && mq[0].inst[0];
    m_issue = m_dv && rdy && !clr && !rob && (m_ls ? !lsb : !rs);
    m_push  = v && !m_full && rdy && !clr;
    if (m_issue) exp_q.push_back('{cyc, mq[0].inst, mq[0].pc, m_ls});
    if (rdy) begin
      if (m_dv && !m_issue && !clr && m_stall != 64'hFFFF_FFFF) m_stall++;
      if (clr) begin
        mq.delete();
        m_flush = 1'b1;
      end else begin
        m_flush = 1'b0;
        if (m_issue) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back('{nxt_inst, nxt_pc});
          nxt_pc   = nxt_pc + 32'd4;
          nxt_inst = $urandom;
        end
      end
    end
    #2;
    cyc++;
  endtask

  task automatic rand_steps(input int n, input int pv, input int pclr, input int prdy,
                            input int prob, input int prs, input int plsb);
    for (int i = 0; i < n; i++)
      step($urandom_range(99) < pv, $urandom_range(99) < pclr, $urandom_range(99) < prdy,
           $urandom_range(99) < prob, $urandom_range(99) < prs, $urandom_range(99) < plsb);
  endtask

  // Monitor: compares every DUT issue strobe with the oldest predicted issue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      #3;
      if (rst_in !== 1'b0) continue;
      if (bus.issue_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got issue_en=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("issue_cycle", 64'(cyc), 64'(e.cyc));
          check("issue_pc", 64'(bus.dec_pc), 64'(e.pc));
          check("issue_inst", 64'(bus.dec_inst), 64'(e.inst));
          check("issue_to_lsb", 64'(bus.issue_to_lsb), 64'(e.to_lsb));
        end
      end else begin
        check("idle_to_lsb", 64'(bus.issue_to_lsb), 64'(0));
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_issue: got issue_en=0 expected 1 pc=%0h (cycle %0d)", e.pc, cyc);
        end
      end
    end
  end

  task automatic reset_model();
    mq.delete();
    exp_q.delete();
    m_flush = 1'b0;
    m_stall = 0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    nxt_pc   = 32'h0;
    nxt_inst = 32'h0000_0010;
    reset_model();
    bus.if_valid = 1'b0;
    bus.if_inst  = '0;
    bus.if_pc    = '0;
    bus.clear_in = 1'b0;
    bus.rdy_in   = 1'b1;
    bus.rob_full = 1'b0;
    bus.rs_full  = 1'b0;
    bus.lsb_full = 1'b0;
    rst_in       = 1'b1;
    #2;
    check("rst_iq_full", 64'(bus.iq_full), 64'(0));
    check("rst_dec_valid", 64'(bus.dec_valid), 64'(0));
    check("rst_issue_en", 64'(bus.issue_en), 64'(0));
    check("rst_issue_to_lsb", 64'(bus.issue_to_lsb), 64'(0));
    check("rst_stall_cnt", 64'(bus.stall_cnt), 64'(0));
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    // Three back-to-back pushes (pc 0,4,8) into free targets, then drain.
    repeat (3) step(1, 0, 1, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0, 0);

    // Fill past capacity with ROB full, then release and drain (pointers wrap).
    repeat (18) step(1, 0, 1, 1, 0, 0);
    repeat (18) step(0, 0, 1, 0, 0, 0);

    // Load/store blocked by LSB, ALU ops blocked by RS.
    rand_steps(60, 60, 0, 100, 0, 50, 50);

    // Clear with five entries queued and fetch offering; then fetch resumes.
    repeat (5) step(1, 0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    repeat (4) step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 1, 0, 0, 0);

    // Steady push+pop at fifteen entries, with a four-cycle rdy_in freeze.
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (15) step(1, 0, 1, 1, 0, 0);
    repeat (8) step(1, 0, 1, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    repeat (8) step(1, 0, 1, 0, 0, 0);

    // Steady push+pop at one entry.
    repeat (20) step(0, 0, 1, 0, 0, 0);
    repeat (12) step(1, 0, 1, 0, 0, 0);

    // Mixed random traffic with flushes and rdy_in gaps.
    for (int seg = 0; seg < 10; seg++)
      rand_steps(50, $urandom_range(30, 100), $urandom_range(0, 8), $urandom_range(60, 100),
                 $urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 60));

    // Asynchronous reset between edges with eight entries queued.
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (8) step(1, 0, 1, 1, 0, 0);
    check("pre_rst_dec_valid", 64'(bus.dec_valid), 64'(1));
    #1;
    rst_in = 1'b1;
    #1;
    check("async_rst_dec_valid", 64'(bus.dec_valid), 64'(0));
    check("async_rst_iq_full", 64'(bus.iq_full), 64'(0));
    check("async_rst_stall_cnt", 64'(bus.stall_cnt), 64'(0));
    reset_model();
    bus.if_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (6) step(1, 0, 1, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending issues expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
